// File: rtl/cpu_speed_pkg.sv
// rtl/cpu_speed_pkg.sv - shared types and constants for the CPU speed policy controller
//
// Contents:
//   speed_state_t  : speed controller FSM states (LS, TO_HS, HS, TO_LS)
//   TURBO_BIT, DIV_LSB, ERRCLR_BIT : control register bit positions
//   *_DEF          : default address map and timing constants
//   in_slow_page() : unsigned page range test for the slow region
package cpu_speed_pkg;

  typedef enum logic [1:0] {
    LS    = 2'd0,
    TO_HS = 2'd1,
    HS    = 2'd2,
    TO_LS = 2'd3
  } speed_state_t;

  localparam int TURBO_BIT  = 0;
  localparam int DIV_LSB    = 1;
  localparam int ERRCLR_BIT = 7;

  localparam logic [7:0]  LS_BASE_DEF   = 8'hFC;
  localparam logic [7:0]  LS_TOP_DEF    = 8'hFE;
  localparam logic [15:0] CTRL_ADDR_DEF = 16'hFE3F;
  localparam int          HOLDOFF_DEF   = 16;
  localparam int          TIMEOUT_DEF   = 255;

  function automatic logic in_slow_page(input logic [7:0] page,
                                        input logic [7:0] base,
                                        input logic [7:0] top);
    return (page >= base) && (page <= top);
  endfunction

endpackage

// File: rtl/cpu_speed_ctrl_sync2.sv
// rtl/cpu_speed_ctrl_sync2.sv - two-flop synchronizer for switch status inputs
//
// Ports:
//   clk : destination clock
//   rst : synchronous active-high reset, clears both flops
//   d   : asynchronous input
//   q   : synchronized output, two clk edges behind d
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/cpu_speed_ctrl.sv
// rtl/cpu_speed_ctrl.sv - PHI2 clock switch policy controller (slow/fast CPU clock selection)
//
// Optional feature macro: CPU_DIV_REG_EN (divider select register; when
// undefined cpuclk_div_sel is tied to 2'b00 and wdata[2:1] is ignored).
//
// Ports:
//   hsclk_in       : fast clock, all logic on its rising edge
//   rst            : synchronous active-high reset
//   addr_vld       : one-cycle strobe qualifying addr/rnw/wdata
//   addr           : CPU address
//   rnw            : 1 = read, 0 = write
//   wdata          : CPU write data (control register writes)
//   hsclk_selected : switch status, asynchronous
//   lsclk_selected : switch status, asynchronous
//   hsclk_sel      : fast clock request to the switch (registered)
//   cpuclk_div_sel : divider select to the switch (registered)
//   busy           : switch handshake in progress (registered)
//   err            : sticky acknowledge timeout (registered)
module cpu_speed_ctrl
  import cpu_speed_pkg::*;
#(
  parameter logic [7:0]  LS_BASE   = LS_BASE_DEF,
  parameter logic [7:0]  LS_TOP    = LS_TOP_DEF,
  parameter logic [15:0] CTRL_ADDR = CTRL_ADDR_DEF,
  parameter int          HOLDOFF   = HOLDOFF_DEF,
  parameter int          TIMEOUT   = TIMEOUT_DEF
) (
  input  logic        hsclk_in,
  input  logic        rst,
  input  logic        addr_vld,
  input  logic [15:0] addr,
  input  logic        rnw,
  input  logic [7:0]  wdata,
  input  logic        hsclk_selected,
  input  logic        lsclk_selected,
  output logic        hsclk_sel,
  output logic [1:0]  cpuclk_div_sel,
  output logic        busy,
  output logic        err
);

  localparam logic [7:0] HOLDOFF_LD   = 8'(HOLDOFF);
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  speed_state_t state, state_next;

  logic       hit;
  logic       ctrl_wr;
  logic       hs_ack;
  logic       ls_ack;
  logic       turbo_en;
  logic       pending;
  logic [7:0] holdoff;
  logic [7:0] wait_cnt;
  logic       waiting;
  logic       ack_done;
  logic       tmo_fire;
  logic       hsclk_sel_d;
  logic       busy_d;

  assign hit     = addr_vld & in_slow_page(addr[15:8], LS_BASE, LS_TOP);
  assign ctrl_wr = addr_vld & ~rnw & (addr == CTRL_ADDR);

  sync2 u_sync_hs (
    .clk (hsclk_in),
    .rst (rst),
    .d   (hsclk_selected),
    .q   (hs_ack)
  );

  sync2 u_sync_ls (
    .clk (hsclk_in),
    .rst (rst),
    .d   (lsclk_selected),
    .q   (ls_ack)
  );

  assign waiting  = (state == TO_HS) || (state == TO_LS);
  // Leaving slow needs the fast side confirmed; leaving fast needs the slow
  // side confirmed with the fast side released (break before make).
  assign ack_done = ((state == TO_HS) & hs_ack) |
                    ((state == TO_LS) & ls_ack & ~hs_ack);
  // An acknowledge arriving on the last allowed cycle still completes.
  assign tmo_fire = waiting & ~ack_done & (wait_cnt == TIMEOUT_LAST);

  // State register
  always_ff @(posedge hsclk_in) begin
    if (rst) begin
      state <= LS;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      LS: begin
        if (turbo_en && (holdoff == 8'd0) && !hit) state_next = TO_HS;
      end
      TO_HS: begin
        if (ack_done)      state_next = HS;
        else if (tmo_fire) state_next = LS;
      end
      HS: begin
        // A hit seen during TO_HS is remembered in pending and forces the exit.
        if (hit || !turbo_en || pending) state_next = TO_LS;
      end
      TO_LS: begin
        if (ack_done || tmo_fire) state_next = LS;
      end
      default: state_next = LS;
    endcase
  end

  // Output decode from the next state so the registered outputs track state
  always_comb begin
    hsclk_sel_d = (state_next == TO_HS) || (state_next == HS);
    busy_d      = (state_next == TO_HS) || (state_next == TO_LS);
  end

  always_ff @(posedge hsclk_in) begin
    if (rst) begin
      hsclk_sel <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
      turbo_en  <= 1'b0;
      pending   <= 1'b0;
      holdoff   <= HOLDOFF_LD;
      wait_cnt  <= 8'd0;
    end else begin
      hsclk_sel <= hsclk_sel_d;
      busy      <= busy_d;

      if (tmo_fire)                             err <= 1'b1;
      else if (ctrl_wr && wdata[ERRCLR_BIT])    err <= 1'b0;

      if (ctrl_wr) turbo_en <= wdata[TURBO_BIT];

      // Reload beats the decrement when a hit lands on the expiring cycle.
      if (hit || tmo_fire)                            holdoff <= HOLDOFF_LD;
      else if ((state == LS) && (holdoff != 8'd0))    holdoff <= holdoff - 8'd1;

      if (state_next != state) wait_cnt <= 8'd0;
      else if (waiting)        wait_cnt <= wait_cnt + 8'd1;

      if ((state_next == LS) || (state_next == TO_LS)) pending <= 1'b0;
      else if ((state == TO_HS) && hit)                pending <= 1'b1;
    end
  end

`ifdef CPU_DIV_REG_EN
  logic [1:0] div_req;
  logic [1:0] div_req_d;
  logic       unused_wdata;

  assign div_req_d    = ctrl_wr ? wdata[DIV_LSB +: 2] : div_req;
  assign unused_wdata = ^wdata[6:3];

  // The divider may only move while the fast clock is idle, i.e. in LS.
  always_ff @(posedge hsclk_in) begin
    if (rst) begin
      div_req        <= 2'b00;
      cpuclk_div_sel <= 2'b00;
    end else begin
      div_req <= div_req_d;
      if (state_next == LS) cpuclk_div_sel <= div_req_d;
    end
  end
`else
  logic unused_wdata;

  assign unused_wdata   = ^wdata[6:1];
  assign cpuclk_div_sel = 2'b00;
`endif

endmodule

// File: doc/cpu_speed_ctrl.md
# cpu_speed_ctrl

Synchronous policy controller that drives the select inputs of the PHI2 clock switch. It decodes CPU addresses to decide when the CPU must run from the slow system clock (I/O and slow regions) versus the fast clock. It performs a request/acknowledge handshake with the switch's selected-status outputs and applies divider changes only while the fast clock is idle. It sits directly upstream of the clock switch and runs entirely on the fast clock domain.

## Interface
Parameters:
- LS_BASE, 8'hFC, first address page (addr[15:8]) requiring slow clock
- LS_TOP, 8'hFE, last address page (inclusive) requiring slow clock
- CTRL_ADDR, 16'hFE3F, address of the write-only control register
- HOLDOFF, 16, fast cycles to remain slow after the last slow-region access (1..255)
- TIMEOUT, 255, max fast cycles to wait for a switch acknowledge (1..255)

Ports:
- hsclk_in  in  1  fast clock; all logic on its rising edge
- rst  in  1  reset, synchronous, active-high
- addr_vld  in  1  one-cycle pulse: addr/rnw/wdata valid for a new CPU access
- addr  in  16  CPU address
- rnw  in  1  1=read, 0=write
- wdata  in  8  CPU write data
- hsclk_selected  in  1  switch status, asynchronous to hsclk_in
- lsclk_selected  in  1  switch status, asynchronous to hsclk_in
- hsclk_sel  out  1  fast-clock request to switch
- cpuclk_div_sel  out  2  divider select to switch
- busy  out  1  handshake in progress
- err  out  1  sticky acknowledge timeout

## Operation
- hit = addr_vld & (LS_BASE <= addr[15:8] <= LS_TOP), unsigned compare.
- Control write: addr_vld & !rnw & addr==CTRL_ADDR. wdata[0]=turbo_en, wdata[2:1]=div_req, wdata[7]=1 clears err. Control write is also a hit when CTRL_ADDR lies in the slow region.
- hsclk_selected, lsclk_selected each pass through a 2-flop synchronizer (hs_ack, ls_ack).
- Holdoff counter (8 bits): loads HOLDOFF on any hit; otherwise decrements in LS while nonzero.
- FSM states:
  - LS: hsclk_sel=0, busy=0. Goes to TO_HS when turbo_en & holdoff==0 & !hit.
  - TO_HS: hsclk_sel=1, busy=1. Goes to HS on hs_ack.
  - HS: hsclk_sel=1, busy=0. Goes to TO_LS on hit, or on !turbo_en.
  - TO_LS: hsclk_sel=0, busy=1. Goes to LS on ls_ack & !hs_ack.
- A hit in TO_HS does not abort it: the switch completes the handshake, then the FSM goes HS→TO_LS on the next cycle. The hit sets a pending flag that forces the HS→TO_LS transition.
- Timeout: a wait counter clears on entry to TO_HS or TO_LS. If it reaches TIMEOUT: err=1, next state LS (hsclk_sel=0), holdoff reloaded.
- cpuclk_div_sel loads div_req only in state LS. A write made in HS is held and applied on the next LS entry. Value 2'b11 is legal and passes through unchanged.
- Reset: state=LS, hsclk_sel=0, cpuclk_div_sel=2'b00, turbo_en=0, div_req=0, holdoff=HOLDOFF, busy=0, err=0, synchronizers=0, pending=0.

## Timing
- All outputs are registered; each output changes one cycle after its cause.
- Acknowledge latency seen by the FSM: switch edge + 2–3 hsclk_in cycles.
- Hit in HS: hsclk_sel low on cycle N+1 after the addr_vld cycle N.
- Earliest return to fast after a hit in LS: HOLDOFF+1 cycles to TO_HS.
- Simultaneous hit and counter expiry: the reload wins.
- rst asserted mid-handshake: reset values on the next edge, no acknowledge needed.

## Configuration
- CPU_DIV_REG_EN defined: div_req register and LS-only update exist as above.
- Undefined: cpuclk_div_sel is the constant 2'b00 and wdata[2:1] is ignored. All other behaviour is unchanged.

## Structure
- Package cpu_speed_pkg holds:
  - FSM state enum (LS, TO_HS, HS, TO_LS)
  - control bit positions (TURBO_BIT=0, DIV_LSB=1, ERRCLR_BIT=7)
  - default address constants
- One sub-module, sync2: a 2-flop synchronizer with synchronous active-high reset, instantiated twice.

## Test plan
- Reset, write 8'h01 to FE3F:
  - hsclk_sel stays 0 for HOLDOFF(16) cycles (the write is a hit).
  - Then TO_HS; raising hsclk_selected gives HS, busy=0 three cycles later.
- In HS, read addr FC10:
  - hsclk_sel=0 next cycle.
  - Raise lsclk_selected and drop hsclk_selected: LS.
  - Returns to TO_HS after 16 idle cycles.
- In HS, hits every 10 cycles: the FSM stays LS throughout; no hsclk_sel pulse.
- Write 8'h05 while in HS: cpuclk_div_sel stays 00 until LS entry, then 2'b10. With the macro undefined it is always 00.
- Never acknowledge TO_HS: after 255 cycles err=1 and hsclk_sel=0. Write 8'h80: err=0.
- Hit issued one cycle after TO_HS entry: the FSM completes TO_HS on acknowledge, then enters TO_LS the next cycle.
